// File: rtl/baccarat_dealer.sv
// Baccarat round sequencer: steps the deal order, applies natural and third-card
// rules, strobes the six card registers one at a time and registers the winner.
module baccarat_dealer #(
  parameter logic [3:0] DRAW_MAX = 4'd5,
  parameter logic [3:0] NAT_MIN  = 4'd8
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       step,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic [2:0] cards_dealt,
  output logic       player_win,
  output logic       dealer_win,
  output logic       done
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LOAD_P1 = 4'd1;
  localparam logic [3:0] WAIT_D1 = 4'd2;
  localparam logic [3:0] LOAD_D1 = 4'd3;
  localparam logic [3:0] WAIT_P2 = 4'd4;
  localparam logic [3:0] LOAD_P2 = 4'd5;
  localparam logic [3:0] WAIT_D2 = 4'd6;
  localparam logic [3:0] LOAD_D2 = 4'd7;
  localparam logic [3:0] EVAL    = 4'd8;
  localparam logic [3:0] WAIT_P3 = 4'd9;
  localparam logic [3:0] LOAD_P3 = 4'd10;
  localparam logic [3:0] EVAL_D  = 4'd11;
  localparam logic [3:0] WAIT_D3 = 4'd12;
  localparam logic [3:0] LOAD_D3 = 4'd13;
  localparam logic [3:0] RESULT  = 4'd14;
  localparam logic [3:0] DONE    = 4'd15;

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic       step_q_r;
  logic       p_drew_r;
  logic       accept_s;
  logic       in_load_s;

  // Banker third-card table; face cards and tens count as zero.
  function automatic logic banker_draws(input logic [3:0] dtot, input logic [3:0] code);
    logic [3:0] v;
    v = (code <= 4'd9) ? code : 4'd0;
    case (dtot)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (v != 4'd8);
      4'd4:             banker_draws = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             banker_draws = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             banker_draws = (v >= 4'd6) && (v <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  endfunction

  assign accept_s  = step & ~step_q_r;
  assign in_load_s = (state_r == LOAD_P1) || (state_r == LOAD_D1) ||
                     (state_r == LOAD_P2) || (state_r == LOAD_D2) ||
                     (state_r == LOAD_P3) || (state_r == LOAD_D3);

  // Next-state logic; accept only moves IDLE and WAIT states, otherwise it is dropped.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = accept_s ? LOAD_P1 : IDLE;
      LOAD_P1: next_state_s = WAIT_D1;
      WAIT_D1: next_state_s = accept_s ? LOAD_D1 : WAIT_D1;
      LOAD_D1: next_state_s = WAIT_P2;
      WAIT_P2: next_state_s = accept_s ? LOAD_P2 : WAIT_P2;
      LOAD_P2: next_state_s = WAIT_D2;
      WAIT_D2: next_state_s = accept_s ? LOAD_D2 : WAIT_D2;
      LOAD_D2: next_state_s = EVAL;
      EVAL: begin
        if ((pscore >= NAT_MIN) || (dscore >= NAT_MIN)) begin
          next_state_s = RESULT;
        end else if (pscore <= DRAW_MAX) begin
          next_state_s = WAIT_P3;
        end else if (dscore <= DRAW_MAX) begin
          next_state_s = WAIT_D3;
        end else begin
          next_state_s = RESULT;
        end
      end
      WAIT_P3: next_state_s = accept_s ? LOAD_P3 : WAIT_P3;
      LOAD_P3: next_state_s = EVAL_D;
      // Only reachable after a player draw; p_drew guards against a corrupted path.
      EVAL_D:  next_state_s = (p_drew_r && banker_draws(dscore, pcard3)) ? WAIT_D3 : RESULT;
      WAIT_D3: next_state_s = accept_s ? LOAD_D3 : WAIT_D3;
      LOAD_D3: next_state_s = RESULT;
      RESULT:  next_state_s = DONE;
      DONE:    next_state_s = DONE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, step edge detector and player-draw flag.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      step_q_r <= 1'b0;
      p_drew_r <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      step_q_r <= step;
      if ((state_r == EVAL) && (next_state_s == WAIT_P3)) begin
        p_drew_r <= 1'b1;
      end
    end
  end

  // Strobes and done are registered from the next state so they track LOAD/DONE exactly.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      load_pcard1 <= 1'b0;
      load_dcard1 <= 1'b0;
      load_pcard2 <= 1'b0;
      load_dcard2 <= 1'b0;
      load_pcard3 <= 1'b0;
      load_dcard3 <= 1'b0;
      done        <= 1'b0;
    end else begin
      load_pcard1 <= (next_state_s == LOAD_P1);
      load_dcard1 <= (next_state_s == LOAD_D1);
      load_pcard2 <= (next_state_s == LOAD_P2);
      load_dcard2 <= (next_state_s == LOAD_D2);
      load_pcard3 <= (next_state_s == LOAD_P3);
      load_dcard3 <= (next_state_s == LOAD_D3);
      done        <= (next_state_s == DONE);
    end
  end

  // Card count advances as each LOAD state is left.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      cards_dealt <= 3'd0;
    end else if (in_load_s) begin
      cards_dealt <= cards_dealt + 3'd1;
    end
  end

  // Winner flags captured on leaving RESULT and held until reset.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      player_win <= 1'b0;
      dealer_win <= 1'b0;
    end else if (state_r == RESULT) begin
      player_win <= (pscore >= dscore);
      dealer_win <= (dscore >= pscore);
    end
  end

endmodule

// File: tb/tb_baccarat_dealer.sv
// Directed bench for baccarat_dealer: drives totals directly and counts strobe pulses.
module tb_baccarat_dealer;

  logic       slow_clock = 1'b0;
  logic       reset;
  logic       step;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic [2:0] cards_dealt;
  logic       player_win, dealer_win, done;
  logic [5:0] strobes;

  int checks    = 0;
  int failures  = 0;
  int multi_cnt = 0;
  int cnt[6]    = '{default: 0};
  int base[6]   = '{default: 0};

  baccarat_dealer dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .step       (step),
    .pscore     (pscore),
    .dscore     (dscore),
    .pcard3     (pcard3),
    .load_pcard1(load_pcard1),
    .load_pcard2(load_pcard2),
    .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1),
    .load_dcard2(load_dcard2),
    .load_dcard3(load_dcard3),
    .cards_dealt(cards_dealt),
    .player_win (player_win),
    .dealer_win (dealer_win),
    .done       (done)
  );

  always #5 slow_clock = ~slow_clock;

  // index order: P1, D1, P2, D2, P3, D3
  assign strobes = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};

  // Strobe pulse counter and simultaneous-strobe detector.
  always @(negedge slow_clock) begin
    for (int i = 0; i < 6; i++) begin
      if (strobes[i]) cnt[i] <= cnt[i] + 1;
    end
    if ($countones(strobes) > 1) multi_cnt <= multi_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 6; i++) base[i] = cnt[i];
  endtask

  task automatic chk_strobes(input string tag, input logic [5:0] exp);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_strobe%0d", tag, i), cnt[i] - base[i], int'(exp[i]));
    end
  endtask

  task automatic chk_end(input string tag, input int cd, input int pw, input int dw, input int dn);
    check({tag, "_cards"}, int'(cards_dealt), cd);
    check({tag, "_pwin"},  int'(player_win),  pw);
    check({tag, "_dwin"},  int'(dealer_win),  dw);
    check({tag, "_done"},  int'(done),        dn);
  endtask

  task automatic press();
    @(negedge slow_clock);
    step = 1'b1;
    @(negedge slow_clock);
    step = 1'b0;
    repeat (4) @(negedge slow_clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step  = 1'b0;
    repeat (2) @(negedge slow_clock);
    reset = 1'b0;
    @(negedge slow_clock);
    snap();
  endtask

  initial begin
    reset  = 1'b1;
    step   = 1'b0;
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;
    repeat (2) @(negedge slow_clock);
    check("rst_strobes", int'(strobes), 0);
    chk_end("rst", 0, 0, 0, 0);

    // Natural: player 9, dealer 7
    do_reset();
    pscore = 4'd9; dscore = 4'd7;
    repeat (4) press();
    chk_strobes("nat", 6'b001111);
    chk_end("nat", 4, 1, 0, 1);

    // Player stands on 6, banker draws from 4 to 9
    do_reset();
    pscore = 4'd6; dscore = 4'd4;
    repeat (4) press();
    check("bdraw_wait_done", int'(done), 0);
    dscore = 4'd9;
    press();
    chk_strobes("bdraw", 6'b101111);
    chk_end("bdraw", 5, 0, 1, 1);

    // Player draws a queen (v=0), banker stands on 6
    do_reset();
    pscore = 4'd3; dscore = 4'd6;
    repeat (4) press();
    pcard3 = 4'd12;
    press();
    chk_strobes("bstand", 6'b011111);
    chk_end("bstand", 5, 0, 1, 1);
    press();
    check("done_ignores_step", int'(cards_dealt), 5);

    // Six cards: player 0 draws 7, banker 3 draws 4, tie at 7
    do_reset();
    pscore = 4'd0; dscore = 4'd3;
    repeat (4) press();
    pcard3 = 4'd7; pscore = 4'd7;
    press();
    check("six_mid_done", int'(done), 0);
    check("six_mid_cards", int'(cards_dealt), 5);
    dscore = 4'd7;
    press();
    chk_strobes("six", 6'b111111);
    chk_end("six", 6, 1, 1, 1);

    // Held step gives one advance; an edge arriving in EVAL is dropped
    do_reset();
    pscore = 4'd2; dscore = 4'd2; pcard3 = 4'd0;
    @(negedge slow_clock);
    step = 1'b1;
    repeat (20) @(negedge slow_clock);
    step = 1'b0;
    repeat (2) @(negedge slow_clock);
    chk_strobes("hold", 6'b000001);
    check("hold_cards", int'(cards_dealt), 1);
    press();
    press();
    @(negedge slow_clock);
    step = 1'b1;
    @(negedge slow_clock);
    step = 1'b0;
    @(negedge slow_clock);
    step = 1'b1;
    repeat (3) @(negedge slow_clock);
    step = 1'b0;
    repeat (3) @(negedge slow_clock);
    chk_strobes("drop_eval", 6'b001111);
    check("drop_eval_cards", int'(cards_dealt), 4);

    // Reset during LOAD_P2
    do_reset();
    press();
    press();
    @(negedge slow_clock);
    step = 1'b1;
    @(posedge slow_clock);
    #1;
    check("lp2_before_rst", int'(load_pcard2), 1);
    reset = 1'b1;
    #1;
    check("lp2_rst_strobes", int'(strobes), 0);
    chk_end("lp2_rst", 0, 0, 0, 0);
    step = 1'b0;
    @(negedge slow_clock);
    reset = 1'b0;
    @(negedge slow_clock);
    snap();
    press();
    chk_strobes("after_rst", 6'b000001);
    check("after_rst_cards", int'(cards_dealt), 1);

    check("one_strobe_at_a_time", multi_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baccarat_dealer.md
Name: baccarat_dealer

Overview:
- Round sequencer for the baccarat datapath: steps the deal order P1, D1, P2, D2, applies the natural and third-card rules, optionally deals P3 and D3, then declares the winner.
- Drives one-cycle load strobes into the six card registers.
- Reads player and dealer totals (0-9) back from the two hand-scoring blocks, plus the raw code of the player's third card.
- Advances one card per operator step (debounced key, synchronous to slow_clock).

Parameters:
- DRAW_MAX, 5: player draws a third card when pscore <= DRAW_MAX. Banker no-P3 rule uses the same threshold.
- NAT_MIN, 8: either total >= NAT_MIN after four cards is a natural; the round ends with no third cards.

Ports:
- slow_clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- step  in  1  operator advance, level; the block edge-detects it internally.
- pscore  in  4  player total 0-9, combinational from the player card registers.
- dscore  in  4  dealer total 0-9, combinational from the dealer card registers.
- pcard3  in  4  raw player third-card code (0 = empty, 1-13 = A..K).
- load_pcard1, load_pcard2, load_pcard3  out  1 each  card-register load strobes.
- load_dcard1, load_dcard2, load_dcard3  out  1 each  card-register load strobes.
- cards_dealt  out  3  count of strobes issued this round, 0-6.
- player_win  out  1  player wins; asserted together with dealer_win means a tie.
- dealer_win  out  1  dealer wins.
- done  out  1  round complete.

Behaviour:
- Reset (async): state=IDLE, step_q=0, all load_*=0, cards_dealt=0, player_win=dealer_win=done=0, p_drew=0.
- Edge detect: step_q<=step every cycle; accept = step & ~step_q.
  - accept is honoured only in IDLE and WAIT_* states. An edge in any other state is dropped, not queued.
  - Holding step high yields exactly one advance.
- States: IDLE, LOAD_P1, WAIT_D1, LOAD_D1, WAIT_P2, LOAD_P2, WAIT_D2, LOAD_D2, EVAL, WAIT_P3, LOAD_P3, EVAL_D, WAIT_D3, LOAD_D3, RESULT, DONE.
- Load strobes:
  - load_x is a Moore output, high exactly for the single cycle spent in LOAD_x.
  - A LOAD state always exits after one cycle, and cards_dealt increments on that exit.
  - At most one strobe is high in any cycle.
  - Latency: accept at edge N puts the FSM in LOAD at cycle N+1; the card register updates at edge N+2.
- Fixed deal sequence:
  - IDLE/WAIT_D1/WAIT_P2/WAIT_D2 advance on accept to LOAD_P1/LOAD_D1/LOAD_P2/LOAD_D2.
  - LOAD_P1->WAIT_D1, LOAD_D1->WAIT_P2, LOAD_P2->WAIT_D2, LOAD_D2->EVAL.
- EVAL (one cycle; scores reflect all four cards):
  - pscore>=NAT_MIN or dscore>=NAT_MIN -> RESULT.
  - else pscore<=DRAW_MAX -> WAIT_P3, p_drew<=1.
  - else dscore<=DRAW_MAX -> WAIT_D3.
  - else -> RESULT.
- LOAD_P3 -> EVAL_D.
- EVAL_D (one cycle): v = pcard3 if pcard3<=9, else 0. Banker draws when any of:
  - dscore<=2;
  - dscore==3 and v!=8;
  - dscore==4 and v in 2..7;
  - dscore==5 and v in 4..7;
  - dscore==6 and v in 6..7.
- EVAL_D transitions: banker draws -> WAIT_D3; otherwise -> RESULT. dscore==7 always stands.
- WAIT_P3 and WAIT_D3 advance on accept; LOAD_D3 -> RESULT.
- RESULT (one cycle), registered on exit to DONE:
  - pscore>dscore -> player_win<=1.
  - dscore>pscore -> dealer_win<=1.
  - equal -> both <=1.
- DONE: done=1. Win flags and cards_dealt are held, and step is ignored until reset.
- Reset mid-round (including during a LOAD cycle): strobe drops immediately, and the FSM restarts from IDLE on release.
- Score inputs are sampled only in EVAL, EVAL_D and RESULT. pcard3 is sampled only in EVAL_D.

Test Plan:
- Natural. Cards P=9,K; D=3,4 (pscore=9, dscore=7), 4 steps. Required: strobes P1,D1,P2,D2 one cycle each, RESULT then DONE, no P3/D3 strobe, cards_dealt=4, player_win=1, dealer_win=0.
- Player stands, banker draws. pscore=6, dscore=4 after 4 cards. Required: EVAL->WAIT_D3, the 5th step gives load_dcard3 only, cards_dealt=5. Final dscore=9 -> dealer_win=1.
- Player draws, banker stands by rule. pscore=3, dscore=6, pcard3=12 (v=0). Required: load_pcard3 strobe, EVAL_D->RESULT with no D3, cards_dealt=5.
- Full six cards. pscore=0, dscore=3, pcard3=7. Required: P3 then D3 strobes on steps 5 and 6. Equal final scores -> player_win=dealer_win=1.
- Step held high for 20 cycles from IDLE. Required: exactly one load_pcard1 pulse. A second press during a LOAD or EVAL cycle is dropped.
- Reset asserted during LOAD_P2. Required: load_pcard2 low immediately and all outputs 0. After release, the next step yields load_pcard1.
